ob_cmd_deser: RTL and testbench

//  Ingress framer directly upstream of the order-book core. Hunts for a

---
 rtl/ob_cmd_deser.sv | 132 +++++++++++++
 tb/tb_ob_cmd_deser.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ob_cmd_deser.sv
// Ingress framer: hunts for SOF, assembles a CMD_W command from bytes and issues it to the core.
// Define OB_CMD_DESER_CHKSUM_EN to require an XOR trailer byte after the body.
module ob_cmd_deser #(
  parameter int         CMD_W     = 64,
  parameter logic [7:0] SOF       = 8'hA5,
  parameter int         TIMEOUT_N = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [7:0]       in_dat,
  output logic             in_rdy,
  input  logic             cmd_full_r,
  output logic             cmd_vld_r,
  output logic [CMD_W-1:0] cmd_r,
  output logic [7:0]       err_cnt_r,
  output logic [15:0]      frm_cnt_r
);

  localparam int               CMD_BYTES = (CMD_W + 7) / 8;
  localparam int               SH_W      = CMD_BYTES * 8;
  localparam int               CNT_W     = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CMD_BYTES - 1);
  localparam logic [15:0]      TMO       = 16'(TIMEOUT_N);

  typedef enum logic [1:0] {IDLE, BODY, CHK, HOLD} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      tmr_q;
  logic [15:0]      tmr_d;
  logic [SH_W-1:0]  shreg_q;
  logic [SH_W-1:0]  shreg_d;
  logic             cmd_vld_q;
  logic [CMD_W-1:0] cmd_q;
  logic [7:0]       err_q;
  logic [7:0]       err_d;
  logic [15:0]      frm_q;
  logic             acc;
`ifdef OB_CMD_DESER_CHKSUM_EN
  logic [7:0]       xor_q;
`endif

  assign in_rdy  = (state_q != HOLD) && !rst;
  assign acc     = in_vld && in_rdy;
  assign tmr_d   = tmr_q + 16'd1;
  // First body byte ends up in the MSBs; its pad bits fall off the top of cmd_r.
  assign shreg_d = (shreg_q << 8) | SH_W'(in_dat);
  assign err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmr_q     <= '0;
      shreg_q   <= '0;
      cmd_vld_q <= 1'b0;
      cmd_q     <= '0;
      err_q     <= '0;
      frm_q     <= '0;
`ifdef OB_CMD_DESER_CHKSUM_EN
      xor_q     <= '0;
`endif
    end else begin
      cmd_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (acc && (in_dat == SOF)) begin
            state_q <= BODY;
            cnt_q   <= '0;
            tmr_q   <= '0;
`ifdef OB_CMD_DESER_CHKSUM_EN
            xor_q   <= '0;
`endif
          end
        end
        BODY: begin
          if (acc) begin
            tmr_q   <= '0;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_q + 1'b1;
`ifdef OB_CMD_DESER_CHKSUM_EN
            xor_q   <= xor_q ^ in_dat;
            if (cnt_q == LAST_CNT) state_q <= CHK;
`else
            if (cnt_q == LAST_CNT) state_q <= HOLD;
`endif
          end else if (tmr_d == TMO) begin
            state_q <= IDLE;
            err_q   <= err_d;
          end else begin
            tmr_q <= tmr_d;
          end
        end
`ifdef OB_CMD_DESER_CHKSUM_EN
        CHK: begin
          if (acc) begin
            tmr_q <= '0;
            if (in_dat == xor_q) begin
              state_q <= HOLD;
            end else begin
              state_q <= IDLE;
              err_q   <= err_d;
            end
          end else if (tmr_d == TMO) begin
            state_q <= IDLE;
            err_q   <= err_d;
          end else begin
            tmr_q <= tmr_d;
          end
        end
`endif
        HOLD: begin
          // Returning to IDLE after the strobe keeps pushes at least two cycles apart.
          if (!cmd_full_r) begin
            cmd_vld_q <= 1'b1;
            cmd_q     <= shreg_q[CMD_W-1:0];
            frm_q     <= frm_q + 16'd1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_vld_r = cmd_vld_q;
  assign cmd_r     = cmd_q;
  assign err_cnt_r = err_q;
  assign frm_cnt_r = frm_q;

endmodule

// File: tb/tb_ob_cmd_deser.sv
// Randomized bench for ob_cmd_deser against a frame-level model (CMD_W=16, TIMEOUT_N=4).
// Works with or without OB_CMD_DESER_CHKSUM_EN defined.
module tb_ob_cmd_deser;

  localparam int         CMD_W     = 16;
  localparam int         TIMEOUT_N = 4;
  localparam logic [7:0] SOF       = 8'hA5;
  localparam int         NB        = (CMD_W + 7) / 8;
`ifdef OB_CMD_DESER_CHKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_vld;
  logic [7:0]       in_dat;
  logic             in_rdy;
  logic             cmd_full_r;
  logic             cmd_vld_r;
  logic [CMD_W-1:0] cmd_r;
  logic [7:0]       err_cnt_r;
  logic [15:0]      frm_cnt_r;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int exp_err = 0;
  int exp_frm = 0;
  logic prev_vld = 1'b0;

  logic [CMD_W-1:0] obs_q[$];
  int               obs_c[$];
  logic [CMD_W-1:0] exp_q[$];

  ob_cmd_deser #(.CMD_W(CMD_W), .SOF(SOF), .TIMEOUT_N(TIMEOUT_N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (in_vld),
    .in_dat    (in_dat),
    .in_rdy    (in_rdy),
    .cmd_full_r(cmd_full_r),
    .cmd_vld_r (cmd_vld_r),
    .cmd_r     (cmd_r),
    .err_cnt_r (err_cnt_r),
    .frm_cnt_r (frm_cnt_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Output monitor: collects every strobe with its cycle and polices back-to-back pushes.
  always @(negedge clk) begin
    if (!rst && cmd_vld_r) begin
      chk("no_b2b", 64'(prev_vld), 64'd0);
      obs_q.push_back(cmd_r);
      obs_c.push_back(cyc);
    end
    prev_vld = cmd_vld_r;
  end

  function automatic logic [CMD_W-1:0] pack(input logic [7:0] b[$]);
    logic [CMD_W-1:0] w = '0;
    foreach (b[i]) w = CMD_W'(w * 256 + b[i]);
    return w;
  endfunction

  function automatic logic [7:0] xsum(input logic [7:0] b[$]);
    logic [7:0] x = 8'h00;
    foreach (b[i]) x = x ^ b[i];
    return x;
  endfunction

  function automatic int sat(input int e);
    return (e >= 255) ? 255 : e + 1;
  endfunction

  task automatic idle(input int n);
    in_vld = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    in_vld = 1'b1;
    in_dat = b;
    @(negedge clk);
    while (!in_rdy && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (!in_rdy) chk("byte_accept_bound", 64'(w), 64'd0);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  // Full frame: SOF, body with random gaps in [gmin,gmax], trailer when checksum is built in.
  task automatic send_frame(input logic [7:0] body[$], input int gmin, input int gmax, input bit bad);
    logic [7:0] tr;
    send_byte(SOF);
    foreach (body[i]) begin
      idle($urandom_range(gmax, gmin));
      send_byte(body[i]);
    end
    if (CK) begin
      tr = xsum(body);
      if (bad) tr = tr ^ 8'($urandom_range(255, 1));
      idle($urandom_range(gmax, gmin));
      send_byte(tr);
    end
    if (CK && bad) begin
      exp_err = sat(exp_err);
    end else begin
      exp_q.push_back(pack(body));
      exp_frm++;
    end
  endtask

  task automatic tmo_frame(input int k);
    send_byte(SOF);
    repeat (k) send_byte(8'($urandom));
    idle(TIMEOUT_N + 1);
    exp_err = sat(exp_err);
  endtask

  task automatic drain(input string tag);
    logic [CMD_W-1:0] o;
    logic [CMD_W-1:0] e;
    idle(4);
    chk({tag, "_ncmd"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_cmd"}, 64'(o), 64'(e));
    end
    obs_q.delete();
    obs_c.delete();
    exp_q.delete();
    chk({tag, "_err"}, 64'(err_cnt_r), 64'(exp_err));
    chk({tag, "_frm"}, 64'(frm_cnt_r), 64'(exp_frm & 16'hFFFF));
  endtask

  function automatic logic [7:0] rnd_body_byte();
    return 8'($urandom);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] j;
    int op;
    int k;
    int st;

    rst = 1'b1;
    in_vld = 1'b0;
    in_dat = 8'h00;
    cmd_full_r = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 64'(in_rdy), 64'd0);
    chk("rst_vld", 64'(cmd_vld_r), 64'd0);
    chk("rst_cmd", 64'(cmd_r), 64'd0);
    chk("rst_err", 64'(err_cnt_r), 64'd0);
    chk("rst_frm", 64'(frm_cnt_r), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", 64'(in_rdy), 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back frame and issue latency.
    q = {8'h12, 8'h34};
    send_frame(q, 0, 0, 1'b0);
    idle(4);
    chk("t1_lat", 64'((obs_c.size() > 0) ? (obs_c[0] - acc_cyc) : -1), 64'd2);
    drain("t1");

    // Leading junk dropped silently.
    send_byte(8'h00);
    send_byte(8'hFF);
    q = {8'hAB, 8'hCD};
    send_frame(q, 0, 0, 1'b0);
    drain("t2");

    // SOF value inside the body is plain data.
    q = {SOF, SOF};
    send_frame(q, 0, 0, 1'b0);
    drain("sof_data");

`ifdef OB_CMD_DESER_CHKSUM_EN
    send_byte(SOF);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h27);
    exp_err = sat(exp_err);
    drain("t3_bad");
    q = {8'h55, 8'h0F};
    send_frame(q, 0, 0, 1'b0);
    drain("t3_good");
`endif

    // Stall mid-frame until timeout; a late body byte is then just junk.
    send_byte(SOF);
    send_byte(8'h12);
    idle(TIMEOUT_N);
    send_byte(8'h34);
    exp_err = sat(exp_err);
    drain("t4");

    // Gaps one short of the timeout must not abort.
    q = {8'h77, 8'h88};
    send_frame(q, TIMEOUT_N - 1, TIMEOUT_N - 1, 1'b0);
    drain("gap_max");

    // Back-pressure hold.
    cmd_full_r = 1'b1;
    q = {8'h5A, 8'hC3};
    send_frame(q, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_rdy", 64'(in_rdy), 64'd0);
      chk("t5_vld", 64'(cmd_vld_r), 64'd0);
    end
    @(posedge clk);
    #1;
    cmd_full_r = 1'b0;
    drain("t5");

    // Reset mid-frame.
    send_byte(SOF);
    send_byte(8'hBE);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_rdy", 64'(in_rdy), 64'd0);
    chk("t6_rst_vld", 64'(cmd_vld_r), 64'd0);
    chk("t6_rst_cmd", 64'(cmd_r), 64'd0);
    chk("t6_rst_err", 64'(err_cnt_r), 64'd0);
    chk("t6_rst_frm", 64'(frm_cnt_r), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_err = 0;
    exp_frm = 0;
    obs_q.delete();
    obs_c.delete();
    exp_q.delete();
    drain("t6_quiet");
    q = {8'hBE, 8'hEF};
    send_frame(q, 0, 0, 1'b0);
    drain("t6_frame");

    // Randomized mix of good, bad, timed-out frames, junk and back-pressure.
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(3, 0);
      q = {};
      for (int b = 0; b < NB; b++) q.push_back(rnd_body_byte());
      case (op)
        0: begin
          st = $urandom_range(1, 0);
          if (st != 0) cmd_full_r = 1'b1;
          send_frame(q, 0, TIMEOUT_N - 1, 1'b0);
          if (st != 0) begin
            idle($urandom_range(6, 1));
            cmd_full_r = 1'b0;
          end
        end
        1: send_frame(q, 0, TIMEOUT_N - 1, 1'b1);
        2: begin
          k = $urandom_range(NB - 1 + int'(CK), 0);
          tmo_frame(k);
        end
        default: begin
          repeat ($urandom_range(3, 1)) begin
            j = 8'($urandom);
            if (j == SOF) j = 8'h00;
            send_byte(j);
          end
        end
      endcase
      drain("rnd");
    end

    // Error counter saturation, then normal operation continues.
    repeat (300) tmo_frame($urandom_range(NB - 1 + int'(CK), 0));
    drain("sat");
    chk("sat_ff", 64'(err_cnt_r), 64'hFF);
    q = {8'h13, 8'h57};
    send_frame(q, 0, 1, 1'b0);
    drain("post_sat");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
